// File: rtl/uart_alu_intf.sv
// UART-to-ALU bridge: collects operand A, operand B and opcode bytes, lets the
// ALU settle for one cycle, then returns the result byte followed by a flag byte.
module uart_alu_intf #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_carry,
  input  logic               i_alu_zero,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND_RES,
    SEND_FLG
  } state_t;

  state_t               state, state_nxt;
  logic [NB_DATA-1:0]   data_a_nxt, data_b_nxt, tx_data_nxt;
  logic [NB_OP-1:0]     op_nxt;
  logic                 tx_start_nxt, overrun_nxt;
  logic [1:0]           flags, flags_nxt;       // {carry, zero} captured at EXEC

  // NOTE: every next-value gets a default first so no path leaves a signal
  // unassigned; otherwise synthesis infers a latch to hold it.
  always_comb begin
    state_nxt    = state;
    data_a_nxt   = o_data_a;
    data_b_nxt   = o_data_b;
    op_nxt       = o_op;
    tx_data_nxt  = o_tx_data;
    flags_nxt    = flags;
    tx_start_nxt = 1'b0;
    overrun_nxt  = o_overrun;

    case (state)
      WAIT_A: if (i_rx_done) begin
        data_a_nxt = i_rx_data;
        state_nxt  = WAIT_B;
      end
      WAIT_B: if (i_rx_done) begin
        data_b_nxt = i_rx_data;
        state_nxt  = WAIT_OP;
      end
      WAIT_OP: if (i_rx_done) begin
        op_nxt    = i_rx_data[NB_OP-1:0];
        state_nxt = EXEC;
      end
      EXEC: begin
        tx_data_nxt  = i_alu_result;
        flags_nxt    = {i_alu_carry, i_alu_zero};
        tx_start_nxt = 1'b1;
        state_nxt    = SEND_RES;
      end
      SEND_RES: if (i_tx_done) begin
        tx_data_nxt  = {{(NB_DATA-2){1'b0}}, flags};
        tx_start_nxt = 1'b1;
        state_nxt    = SEND_FLG;
      end
      SEND_FLG: if (i_tx_done) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase

    // Bytes arriving while a response is pending have nowhere to go.
    if (i_rx_done && (state == EXEC || state == SEND_RES || state == SEND_FLG))
      overrun_nxt = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= WAIT_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      flags      <= '0;
      o_tx_start <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_data_a   <= data_a_nxt;
      o_data_b   <= data_b_nxt;
      o_op       <= op_nxt;
      o_tx_data  <= tx_data_nxt;
      flags      <= flags_nxt;
      o_tx_start <= tx_start_nxt;
      o_overrun  <= overrun_nxt;
    end
  end

  assign o_busy = (state == EXEC) || (state == SEND_RES) || (state == SEND_FLG);

endmodule

// File: tb/tb_uart_alu_intf.sv
// Self-checking bench for uart_alu_intf: a behavioural ALU and a scoreboard of
// expected transmit bytes, checked by a monitor on every falling edge.
module tb_uart_alu_intf;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] i_alu_result;
  logic       i_alu_carry;
  logic       i_alu_zero;
  logic       i_tx_done;
  logic [7:0] o_data_a, o_data_b, o_tx_data;
  logic [5:0] o_op;
  logic       o_tx_start, o_busy, o_overrun;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       exp_overrun = 1'b0;
  logic       prev_start  = 1'b0;
  logic [7:0] alu_xor     = 8'h00;

  always #5 i_clk = ~i_clk;

  uart_alu_intf #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .i_alu_result(i_alu_result),
    .i_alu_carry (i_alu_carry),
    .i_alu_zero  (i_alu_zero),
    .i_tx_done   (i_tx_done),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_op        (o_op),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  // Reference ALU: returns {carry, result}.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    logic [8:0] r;
    case (op)
      6'h20: r = {1'b0, a} + {1'b0, b};
      6'h22: r = {1'b0, a} - {1'b0, b};
      6'h24: r = {1'b0, a & b};
      6'h25: r = {1'b0, a | b};
      6'h26: r = {1'b0, a ^ b};
      6'h27: r = {1'b0, ~(a | b)};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] flag_f(input logic [8:0] r);
    return {6'b0, r[8], (r[7:0] == 8'h00)};
  endfunction

  // The bench plays the ALU; alu_xor disturbs it after EXEC to prove sampling.
  logic [8:0] alu_raw;
  assign alu_raw      = alu_f(o_data_a, o_data_b, o_op);
  assign i_alu_result = alu_raw[7:0] ^ alu_xor;
  assign i_alu_carry  = alu_raw[8] ^ alu_xor[0];
  assign i_alu_zero   = (alu_raw[7:0] == 8'h00) ^ alu_xor[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    exp_overrun = 1'b0;
    exp_q.delete();
    check("rst_data_a", o_data_a, 0);
    check("rst_data_b", o_data_b, 0);
    check("rst_op", o_op, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
  endtask

  // inj: 0 none, 1 extra rx byte during SEND_RES, 2 rx together with final tx_done.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [7:0] er, input logic [7:0] ef,
                         input int d, input int inj);
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    check("op_a", o_data_a, a);
    check("op_b", o_data_b, b);
    check("op_code", o_op, opb[5:0]);
    check("exec_busy", o_busy, 1);
    check("exec_no_start", o_tx_start, 0);
    exp_q.push_back(er);
    exp_q.push_back(ef);
    tick();
    check("latency_start", o_tx_start, 1);
    alu_xor = 8'($urandom);
    for (int i = 0; i < d; i++) begin
      if (inj == 1 && i == 0) begin
        send_byte(8'($urandom));
        exp_overrun = 1'b1;
      end else begin
        tick();
      end
    end
    check("res_hold", o_tx_data, er);
    check("res_busy", o_busy, 1);
    pulse_tx_done();
    check("flg_start", o_tx_start, 1);
    for (int i = 0; i < d; i++) tick();
    if (inj == 2) begin
      i_rx_data = ~a;
      i_rx_done = 1'b1;
      i_tx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
      i_tx_done = 1'b0;
      exp_overrun = 1'b1;
      check("drop_a", o_data_a, a);
    end else begin
      pulse_tx_done();
    end
    check("idle_busy", o_busy, 0);
    check("flg_hold", o_tx_data, ef);
    alu_xor = 8'h00;
  endtask

  // Monitor: every transmit pulse must match the scoreboard; flags checked each cycle.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      check("tx_start_width", {31'b0, o_tx_start & prev_start}, 0);
      check("overrun", o_overrun, exp_overrun);
      if (o_tx_start) begin
        if (exp_q.size() == 0) check("spurious_tx_start", o_tx_start, 0);
        else check("tx_byte", o_tx_data, exp_q.pop_front());
      end
      prev_start = o_tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    logic [5:0] ops[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    i_reset = 1'b1; i_rx_data = '0; i_rx_done = 1'b0; i_tx_done = 1'b0;
    repeat (2) tick();
    do_reset();

    // Pin the reference ALU with hand-computed values.
    check("model_add", alu_f(8'h0F, 8'h0A, 6'h20), 9'h019);
    check("model_add_c", alu_f(8'hC8, 8'h64, 6'h20), 9'h12C);
    check("model_flag_cz", flag_f(alu_f(8'h80, 8'h80, 6'h20)), 8'h03);
    check("model_and", alu_f(8'hAA, 8'h55, 6'h24), 9'h000);

    run_txn(8'h0F, 8'h0A, 8'h20, 8'h19, 8'h00, 3, 0);
    run_txn(8'hC8, 8'h64, 8'h20, 8'h2C, 8'h02, 2, 0);
    run_txn(8'h80, 8'h80, 8'h20, 8'h00, 8'h03, 1, 0);
    run_txn(8'hAA, 8'h55, 8'hE4, 8'h00, 8'h01, 4, 0);
    check("op_masked", o_op, 6'h24);

    // Byte during SEND_RES, then a clean transaction.
    run_txn(8'h0F, 8'h0A, 8'h20, 8'h19, 8'h00, 3, 1);
    run_txn(8'h01, 8'h01, 8'h20, 8'h02, 8'h00, 2, 0);

    // rx_done together with final tx_done.
    run_txn(8'h10, 8'h20, 8'h20, 8'h30, 8'h00, 2, 2);
    check("after_collision_busy", o_busy, 0);

    // Stray tx_done while idle must be ignored.
    pulse_tx_done();
    tick();
    check("idle_txdone_busy", o_busy, 0);

    // Reset mid-transaction in WAIT_OP.
    send_byte(8'h0F);
    send_byte(8'h0A);
    check("waitop_busy", o_busy, 0);
    do_reset();
    run_txn(8'h01, 8'h02, 8'h20, 8'h03, 8'h00, 2, 0);

    // Long wait for tx_done: data stays, no extra pulse.
    run_txn(8'h33, 8'h44, 8'h20, 8'h77, 8'h00, 100, 0);

    for (int n = 0; n < 30; n++) begin
      logic [7:0] a, b, opb;
      logic [8:0] r;
      a   = 8'($urandom);
      b   = 8'($urandom);
      opb = {2'($urandom), ops[$urandom_range(0, 5)]};
      r   = alu_f(a, b, opb[5:0]);
      run_txn(a, b, opb, r[7:0], flag_f(r), $urandom_range(1, 4), 0);
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_intf.md
UART_ALU_INTF -- requirements
Module: uart_alu_intf

Interface
REQ-001 Parameter NB_DATA, default 8: width of operands, result and UART bytes.
REQ-002 Parameter NB_OP, default 6: width of the ALU operation code.
REQ-003 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_rx_data  input  NB_DATA  byte from the UART receiver; valid only while i_rx_done=1.
REQ-006 i_rx_done  input  1  one-cycle pulse marking a received byte.
REQ-007 i_alu_result  input  NB_DATA  combinational ALU result for the current o_data_a/o_data_b/o_op.
REQ-008 i_alu_carry  input  1  combinational ALU carry flag.
REQ-009 i_alu_zero  input  1  combinational ALU zero flag.
REQ-010 i_tx_done  input  1  one-cycle pulse from the UART transmitter marking the end of the current byte.
REQ-011 o_data_a  output  NB_DATA  registered operand A to the ALU.
REQ-012 o_data_b  output  NB_DATA  registered operand B to the ALU.
REQ-013 o_op  output  NB_OP  registered operation code to the ALU.
REQ-014 o_tx_data  output  NB_DATA  byte to transmit; stable from the o_tx_start pulse until the next i_tx_done.
REQ-015 o_tx_start  output  1  registered one-cycle pulse requesting transmission of o_tx_data.
REQ-016 o_busy  output  1  high while a computation or response is in progress.
REQ-017 o_overrun  output  1  sticky flag: a received byte was dropped.

Function
REQ-018 States SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES and SEND_FLG; encoding is free.
REQ-019 WAIT_A + i_rx_done at edge k: o_data_a <= i_rx_data; state WAIT_B from k+1.
REQ-020 WAIT_B + i_rx_done: o_data_b <= i_rx_data; state -> WAIT_OP.
REQ-021 WAIT_OP + i_rx_done: o_op <= i_rx_data[NB_OP-1:0]; bits above NB_OP are ignored; state -> EXEC.
REQ-022 EXEC lasts exactly one cycle, which lets the combinational ALU settle.
REQ-023 At the EXEC edge: o_tx_data <= i_alu_result; flag byte {zeros, i_alu_carry, i_alu_zero} captured internally (carry bit1, zero bit0); o_tx_start high the following cycle; state -> SEND_RES.
REQ-024 SEND_RES + i_tx_done: o_tx_data <= flag byte; o_tx_start pulses one cycle; state -> SEND_FLG.
REQ-025 SEND_FLG + i_tx_done: state -> WAIT_A; no pulse.
REQ-026 Latency from the op-byte i_rx_done edge to o_tx_start high SHALL be 2 cycles.
REQ-027 o_tx_start SHALL never be high for more than one consecutive cycle.
REQ-028 o_busy = 1 in EXEC, SEND_RES and SEND_FLG; 0 otherwise.
REQ-029 i_rx_done in EXEC, SEND_RES or SEND_FLG: byte dropped and o_overrun <= 1; the current transaction continues unaffected.
REQ-030 i_rx_done and i_tx_done in the same SEND_FLG cycle: state -> WAIT_A, byte dropped, o_overrun <= 1.
REQ-031 i_tx_done outside SEND_RES/SEND_FLG SHALL be ignored.
REQ-032 o_data_a, o_data_b and o_op SHALL hold their values until overwritten by a later byte.
REQ-033 The ALU result SHALL be sampled only at the EXEC edge; later changes to the ALU inputs do not alter the bytes sent.

Reset
REQ-034 i_reset=1 at an edge: state WAIT_A; o_data_a, o_data_b, o_op, o_tx_data = 0; o_tx_start, o_busy, o_overrun = 0; captured flags = 0.
REQ-035 Reset SHALL take priority over all other inputs in any state, including mid-transaction; the partial transaction is discarded.
REQ-036 o_overrun SHALL clear only on reset.

Verification
REQ-037 Rx 0x0F, 0x0A, 0x20 (ADD); ALU model 8-bit add -> tx bytes 0x19 then 0x00; o_overrun=0.
REQ-038 Rx 0xC8, 0x64, 0x20 -> tx 0x2C then 0x02; rx 0x80, 0x80, 0x20 -> tx 0x00 then 0x03.
REQ-039 Rx 0xAA, 0x55, 0xE4 -> o_op=0x24 (AND); tx 0x00 then 0x01.
REQ-040 Rx byte during SEND_RES -> o_overrun=1; tx 0x19/0x00 sequence still completes; next transaction starts clean in WAIT_A.
REQ-041 Reset asserted in WAIT_OP after A=0x0F, B=0x0A -> all outputs 0; then rx 0x01, 0x02, 0x20 -> tx 0x03 then 0x00.
REQ-042 Check o_tx_start high exactly 2 cycles after the op-byte i_rx_done; hold i_tx_done low 100 cycles -> o_tx_data stable, no further o_tx_start pulse.
